// File: rtl/mem_blk_xfer_ctrl_if.sv
// Purpose: bundles the arbiter request/completion signals and the memory-controller beat bus
//          of mem_blk_xfer_ctrl into one interface.
// Ports:   slave = the transfer controller; master = arbiter + memory controller side.
interface mem_blk_xfer_ctrl_if #(
    parameter int WORD_SIZE     = 32,
    parameter int CL_SIZE_WIDTH = 512,
    parameter int ADDR_BITCOUNT = 64
);
    // arbiter side
    logic                     req_valid;
    logic                     req_wr;
    logic [ADDR_BITCOUNT-1:0] req_addr;
    logic [CL_SIZE_WIDTH-1:0] req_wdata;
    logic                     req_ready;
    logic                     rsp_valid;
    logic                     rsp_err;
    logic [CL_SIZE_WIDTH-1:0] rsp_rdata;

    // memory-controller side
    logic [1:0]               op;
    logic [WORD_SIZE-1:0]     common_data_bus_write_out;
    logic [WORD_SIZE-1:0]     common_data_bus_read_in;
    logic                     ready;
    logic                     tx_done;
    logic                     rd_valid;

    modport slave (
        input  req_valid, req_wr, req_addr, req_wdata,
        input  common_data_bus_read_in, ready, tx_done, rd_valid,
        output req_ready, rsp_valid, rsp_err, rsp_rdata,
        output op, common_data_bus_write_out
    );

    modport master (
        output req_valid, req_wr, req_addr, req_wdata,
        output common_data_bus_read_in, ready, tx_done, rd_valid,
        input  req_ready, rsp_valid, rsp_err, rsp_rdata,
        input  op, common_data_bus_write_out
    );
endinterface

// File: rtl/mem_blk_xfer_ctrl.sv
// Purpose: sequences one cache-line transfer (addr lo, addr hi, 16 data beats) to the memory controller.
// Latency: accept -> rsp_valid is 19 cycles with no stalls; req_ready returns the cycle after rsp_valid.
// Backpressure: ready stalls address/write beats, rd_valid paces read beats; req_ready low while busy.
// Ports: clk, rst (async active-low), xfer (slave modport: request/completion + beat bus).
module mem_blk_xfer_ctrl #(
    parameter int WORD_SIZE     = 32,
    parameter int CL_SIZE_WIDTH = 512,
    parameter int ADDR_BITCOUNT = 64
) (
    input  logic                clk,
    input  logic                rst,
    mem_blk_xfer_ctrl_if.slave  xfer
);
    localparam int BEATS  = CL_SIZE_WIDTH / WORD_SIZE;
    localparam int BEAT_W = $clog2(BEATS);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    typedef enum logic [2:0] {
        IDLE, ADDR_LO, ADDR_HI, WR_DATA, RD_DATA, WAIT_DONE, RESP
    } state_t;

    state_t                   state;
    state_t                   nextState;
    logic [BEAT_W-1:0]        beat;
    logic                     isWr;
    logic [ADDR_BITCOUNT-1:0] addrQ;
    logic [CL_SIZE_WIDTH-1:0] wdataQ;
    logic [CL_SIZE_WIDTH-1:0] rdataQ;
    logic                     errQ;

    logic                     accept;
    logic                     beatAdv;
    logic                     lastBeat;
    logic                     earlyDone;
    logic [1:0]               opSel;

    assign accept   = (state == IDLE) && xfer.req_valid;
    assign beatAdv  = ((state == WR_DATA) && xfer.ready) || ((state == RD_DATA) && xfer.rd_valid);
    assign lastBeat = beatAdv && (beat == LAST_BEAT);
    assign opSel    = isWr ? 2'b11 : 2'b01;

    // tx_done before the final beat has been transferred ends the transfer as an error;
    // it takes priority over any beat offered in the same cycle.
    always_comb begin
        earlyDone = 1'b0;
        if (xfer.tx_done) begin
            case (state)
                ADDR_LO, ADDR_HI: earlyDone = 1'b1;
                WR_DATA, RD_DATA: earlyDone = !lastBeat;
                default:          earlyDone = 1'b0;
            endcase
        end
    end

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // next-state logic
    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (xfer.req_valid) nextState = ADDR_LO;
            end
            ADDR_LO: begin
                if (earlyDone)       nextState = RESP;
                else if (xfer.ready) nextState = ADDR_HI;
            end
            ADDR_HI: begin
                if (earlyDone)       nextState = RESP;
                else if (xfer.ready) nextState = isWr ? WR_DATA : RD_DATA;
            end
            WR_DATA, RD_DATA: begin
                if (lastBeat)        nextState = xfer.tx_done ? RESP : WAIT_DONE;
                else if (earlyDone)  nextState = RESP;
            end
            WAIT_DONE: begin
                if (xfer.tx_done)    nextState = RESP;
            end
            RESP:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // latched request, beat counter, error flag and read-line assembly
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beat   <= '0;
            isWr   <= 1'b0;
            addrQ  <= '0;
            wdataQ <= '0;
            rdataQ <= '0;
            errQ   <= 1'b0;
        end else if (accept) begin
            isWr   <= xfer.req_wr;
            addrQ  <= xfer.req_addr;
            wdataQ <= xfer.req_wdata;
            beat   <= '0;
            errQ   <= 1'b0;
        end else if (earlyDone) begin
            errQ   <= 1'b1;
        end else if (beatAdv) begin
            // wraps 15 -> 0 exactly as the data phase is left
            beat <= beat + BEAT_W'(1);
            if (state == RD_DATA) begin
                rdataQ[int'(beat)*WORD_SIZE +: WORD_SIZE] <= xfer.common_data_bus_read_in;
            end
        end
    end

    // outputs decoded purely from registered state
    always_comb begin
        xfer.req_ready                 = 1'b0;
        xfer.rsp_valid                 = 1'b0;
        xfer.rsp_err                   = 1'b0;
        xfer.op                        = 2'b00;
        xfer.common_data_bus_write_out = '0;
        case (state)
            IDLE: begin
                xfer.req_ready = 1'b1;
            end
            ADDR_LO: begin
                xfer.op                        = opSel;
                xfer.common_data_bus_write_out = addrQ[WORD_SIZE-1:0];
            end
            ADDR_HI: begin
                xfer.op                        = opSel;
                xfer.common_data_bus_write_out = addrQ[ADDR_BITCOUNT-1 -: WORD_SIZE];
            end
            WR_DATA: begin
                xfer.op                        = opSel;
                xfer.common_data_bus_write_out = wdataQ[int'(beat)*WORD_SIZE +: WORD_SIZE];
            end
            RD_DATA, WAIT_DONE: begin
                xfer.op = opSel;
            end
            RESP: begin
                xfer.rsp_valid = 1'b1;
                xfer.rsp_err   = errQ;
            end
            default: begin
                xfer.req_ready = 1'b0;
            end
        endcase
    end

    assign xfer.rsp_rdata = rdataQ;

endmodule

// File: tb/tb_mem_blk_xfer_ctrl.sv
// Purpose: directed self-checking bench for mem_blk_xfer_ctrl.
// Latency: cycle 0 is the accept cycle; outputs are sampled 1 ns after each rising edge.
// Backpressure: ready / rd_valid / tx_done driven from per-cycle tables in each scenario.
module tb_mem_blk_xfer_ctrl;
    localparam int WS = 32;
    localparam int CL = 512;
    localparam int AW = 64;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_blk_xfer_ctrl_if #(.WORD_SIZE(WS), .CL_SIZE_WIDTH(CL), .ADDR_BITCOUNT(AW)) xif ();

    mem_blk_xfer_ctrl #(.WORD_SIZE(WS), .CL_SIZE_WIDTH(CL), .ADDR_BITCOUNT(AW)) dut (
        .clk  (clk),
        .rst  (rst),
        .xfer (xif.slave)
    );

    int tests = 0;
    int fails = 0;
    logic [CL-1:0] expLine;   // expected rsp_rdata, maintained by the bench

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        xif.req_valid               = 1'b0;
        xif.req_wr                  = 1'b0;
        xif.req_addr                = '0;
        xif.req_wdata               = '0;
        xif.common_data_bus_read_in = '0;
        xif.ready                   = 1'b0;
        xif.tx_done                 = 1'b0;
        xif.rd_valid                = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b0;
        #3;
        tests++; if (xif.req_ready !== 1'b1) begin fails++; $display("FAIL reset_req_ready: got %b exp 1", xif.req_ready); end
        tests++; if (xif.rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid: got %b exp 0", xif.rsp_valid); end
        tests++; if (xif.rsp_err !== 1'b0) begin fails++; $display("FAIL reset_rsp_err: got %b exp 0", xif.rsp_err); end
        tests++; if (xif.rsp_rdata !== '0) begin fails++; $display("FAIL reset_rsp_rdata: got %h exp 0", xif.rsp_rdata); end
        tests++; if (xif.op !== 2'b00) begin fails++; $display("FAIL reset_op: got %b exp 00", xif.op); end
        tests++; if (xif.common_data_bus_write_out !== 32'h0) begin fails++; $display("FAIL reset_bus: got %h exp 0", xif.common_data_bus_write_out); end
        expLine = '0;
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_write_nostall();
        logic [AW-1:0] a;
        logic [CL-1:0] wd;
        logic [WS-1:0] eb;
        a = 64'h0000_0001_0000_0040;
        for (int i = 0; i < 16; i++) wd[i*32 +: 32] = 32'hA000_0000 + 32'(i);
        xif.req_valid = 1'b1; xif.req_wr = 1'b1; xif.req_addr = a; xif.req_wdata = wd;
        xif.ready = 1'b1; xif.tx_done = 1'b0;
        tests++; if (xif.req_ready !== 1'b1) begin fails++; $display("FAIL wr0_accept_ready: got %b exp 1", xif.req_ready); end
        for (int c = 1; c <= 20; c++) begin
            tick();
            xif.req_valid = 1'b0;
            if (c == 1)       eb = a[31:0];
            else if (c == 2)  eb = a[63:32];
            else if (c <= 18) eb = wd[(c-3)*32 +: 32];
            else              eb = '0;
            tests++; if (xif.common_data_bus_write_out !== eb) begin fails++; $display("FAIL wr0_bus c%0d: got %h exp %h", c, xif.common_data_bus_write_out, eb); end
            tests++; if (xif.op !== ((c <= 18) ? 2'b11 : 2'b00)) begin fails++; $display("FAIL wr0_op c%0d: got %b", c, xif.op); end
            tests++; if (xif.rsp_valid !== (c == 19)) begin fails++; $display("FAIL wr0_rsp_valid c%0d: got %b exp %b", c, xif.rsp_valid, c == 19); end
            tests++; if (xif.req_ready !== (c == 20)) begin fails++; $display("FAIL wr0_req_ready c%0d: got %b exp %b", c, xif.req_ready, c == 20); end
            if (c == 19) begin
                tests++; if (xif.rsp_err !== 1'b0) begin fails++; $display("FAIL wr0_rsp_err: got %b exp 0", xif.rsp_err); end
                tests++; if (xif.rsp_rdata !== expLine) begin fails++; $display("FAIL wr0_rdata_kept: got %h exp %h", xif.rsp_rdata, expLine); end
            end
            xif.tx_done = (c == 18);
        end
    endtask

    task automatic test_read_stall();
        int k;
        int rspCnt;
        int rspCyc;
        k = 0; rspCnt = 0; rspCyc = -1;
        xif.req_valid = 1'b1; xif.req_wr = 1'b0; xif.req_addr = 64'h80;
        xif.req_wdata = {16{32'h5A5A_5A5A}};
        xif.ready = 1'b1; xif.tx_done = 1'b0;
        xif.rd_valid = 1'b1; xif.common_data_bus_read_in = 32'hDEAD_BEEF;
        for (int c = 1; c <= 55; c++) begin
            tick();
            xif.req_valid = 1'b0;
            if (xif.rsp_valid === 1'b1) begin
                rspCnt++; rspCyc = c;
                tests++; if (xif.rsp_err !== 1'b0) begin fails++; $display("FAIL rd_rsp_err: got %b exp 0", xif.rsp_err); end
            end
            if (c <= 48) begin
                tests++; if (xif.op !== 2'b01) begin fails++; $display("FAIL rd_op c%0d: got %b exp 01", c, xif.op); end
            end
            if (c >= 3 && c <= 48) begin
                tests++; if (xif.common_data_bus_write_out !== 32'h0) begin fails++; $display("FAIL rd_bus c%0d: got %h exp 0", c, xif.common_data_bus_write_out); end
            end
            xif.tx_done = 1'b0; xif.rd_valid = 1'b0;
            xif.common_data_bus_read_in = 32'hBAD0_0000 + 32'(c);
            if (c <= 2) begin
                // rd_valid during the address phase must be ignored
                xif.rd_valid = 1'b1;
            end else if (k < 16 && ((c - 3) % 3 == 0)) begin
                xif.rd_valid = 1'b1;
                xif.common_data_bus_read_in = 32'h1111_0000 + 32'(k);
                xif.tx_done = (k == 15);
                k++;
            end
        end
        tests++; if (rspCnt != 1) begin fails++; $display("FAIL rd_rsp_count: got %0d exp 1", rspCnt); end
        tests++; if (rspCyc != 49) begin fails++; $display("FAIL rd_rsp_cycle: got %0d exp 49", rspCyc); end
        for (int i = 0; i < 16; i++) expLine[i*32 +: 32] = 32'h1111_0000 + 32'(i);
        for (int i = 0; i < 16; i++) begin
            tests++; if (xif.rsp_rdata[i*32 +: 32] !== expLine[i*32 +: 32]) begin fails++; $display("FAIL rd_word%0d: got %h exp %h", i, xif.rsp_rdata[i*32 +: 32], expLine[i*32 +: 32]); end
        end
    endtask

    task automatic test_write_stall();
        logic [AW-1:0] a;
        logic [CL-1:0] wd;
        logic [WS-1:0] expBus [1:23];
        logic rdyTab [0:23];
        a = 64'h1234_5678_9ABC_DEF0;
        for (int i = 0; i < 16; i++) wd[i*32 +: 32] = 32'hC000_0000 + 32'(i);
        for (int c = 0; c <= 23; c++) rdyTab[c] = !(c == 2 || c == 3 || c == 4 || c == 13 || c == 14);
        expBus[1] = a[31:0];
        for (int c = 2; c <= 5; c++) expBus[c] = a[63:32];
        for (int i = 0; i <= 6; i++) expBus[6+i] = wd[i*32 +: 32];
        for (int c = 13; c <= 15; c++) expBus[c] = wd[7*32 +: 32];
        for (int i = 8; i <= 15; i++) expBus[8+i] = wd[i*32 +: 32];
        xif.req_valid = 1'b1; xif.req_wr = 1'b1; xif.req_addr = a; xif.req_wdata = wd;
        xif.ready = rdyTab[0]; xif.tx_done = 1'b0; xif.rd_valid = 1'b0;
        for (int c = 1; c <= 25; c++) begin
            tick();
            xif.req_valid = 1'b0;
            if (c <= 23) begin
                tests++; if (xif.common_data_bus_write_out !== expBus[c]) begin fails++; $display("FAIL wrs_bus c%0d: got %h exp %h", c, xif.common_data_bus_write_out, expBus[c]); end
                tests++; if (xif.op !== 2'b11) begin fails++; $display("FAIL wrs_op c%0d: got %b exp 11", c, xif.op); end
            end
            tests++; if (xif.rsp_valid !== (c == 24)) begin fails++; $display("FAIL wrs_rsp_valid c%0d: got %b exp %b", c, xif.rsp_valid, c == 24); end
            if (c == 24) begin
                tests++; if (xif.rsp_err !== 1'b0) begin fails++; $display("FAIL wrs_rsp_err: got %b exp 0", xif.rsp_err); end
            end
            xif.ready   = (c <= 23) ? rdyTab[c] : 1'b1;
            xif.tx_done = (c == 23);
        end
        tests++; if (xif.rsp_rdata !== expLine) begin fails++; $display("FAIL wrs_rdata_kept: got %h exp %h", xif.rsp_rdata, expLine); end
    endtask

    task automatic test_early_done();
        xif.req_valid = 1'b1; xif.req_wr = 1'b0; xif.req_addr = 64'h100;
        xif.ready = 1'b1; xif.tx_done = 1'b0; xif.rd_valid = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            xif.req_valid = 1'b0;
            if (c == 9) begin
                tests++; if (xif.rsp_valid !== 1'b1) begin fails++; $display("FAIL early_rsp_valid: got %b exp 1", xif.rsp_valid); end
                tests++; if (xif.rsp_err !== 1'b1) begin fails++; $display("FAIL early_rsp_err: got %b exp 1", xif.rsp_err); end
                tests++; if (xif.op !== 2'b00) begin fails++; $display("FAIL early_op: got %b exp 00", xif.op); end
            end
            if (c == 10) begin
                tests++; if (xif.req_ready !== 1'b1) begin fails++; $display("FAIL early_req_ready: got %b exp 1", xif.req_ready); end
            end
            xif.rd_valid = (c >= 3 && c <= 7);
            xif.common_data_bus_read_in = 32'h2222_0000 + 32'(c - 3);
            xif.tx_done = (c == 8);
        end
        for (int i = 0; i < 5; i++) expLine[i*32 +: 32] = 32'h2222_0000 + 32'(i);
        for (int i = 0; i < 16; i++) begin
            tests++; if (xif.rsp_rdata[i*32 +: 32] !== expLine[i*32 +: 32]) begin fails++; $display("FAIL early_word%0d: got %h exp %h", i, xif.rsp_rdata[i*32 +: 32], expLine[i*32 +: 32]); end
        end
        // follow-up write must complete cleanly
        xif.req_valid = 1'b1; xif.req_wr = 1'b1; xif.req_addr = 64'h140; xif.req_wdata = {16{32'h0F0F_0F0F}};
        xif.ready = 1'b1; xif.tx_done = 1'b0; xif.rd_valid = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            xif.req_valid = 1'b0;
            if (c == 19) begin
                tests++; if (xif.rsp_valid !== 1'b1) begin fails++; $display("FAIL early_next_rsp_valid: got %b exp 1", xif.rsp_valid); end
                tests++; if (xif.rsp_err !== 1'b0) begin fails++; $display("FAIL early_next_rsp_err: got %b exp 0", xif.rsp_err); end
            end
            xif.tx_done = (c == 18);
        end
    endtask

    task automatic test_reset_mid();
        logic [CL-1:0] wd;
        for (int i = 0; i < 16; i++) wd[i*32 +: 32] = 32'hD000_0000 + 32'(i);
        xif.req_valid = 1'b1; xif.req_wr = 1'b1; xif.req_addr = 64'h180; xif.req_wdata = wd;
        xif.ready = 1'b1; xif.tx_done = 1'b0; xif.rd_valid = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            xif.req_valid = 1'b0;
        end
        tests++; if (xif.common_data_bus_write_out !== wd[9*32 +: 32]) begin fails++; $display("FAIL rstm_beat9_bus: got %h exp %h", xif.common_data_bus_write_out, wd[9*32 +: 32]); end
        rst = 1'b0;
        #1;
        tests++; if (xif.op !== 2'b00) begin fails++; $display("FAIL rstm_op: got %b exp 00", xif.op); end
        tests++; if (xif.req_ready !== 1'b1) begin fails++; $display("FAIL rstm_req_ready: got %b exp 1", xif.req_ready); end
        tests++; if (xif.rsp_valid !== 1'b0) begin fails++; $display("FAIL rstm_rsp_valid: got %b exp 0", xif.rsp_valid); end
        expLine = '0;
        tests++; if (xif.rsp_rdata !== expLine) begin fails++; $display("FAIL rstm_rdata: got %h exp 0", xif.rsp_rdata); end
        tick();
        tick();
        rst = 1'b1;
        tick();
        // fresh zero-stall read
        xif.req_valid = 1'b1; xif.req_wr = 1'b0; xif.req_addr = 64'h200;
        for (int c = 1; c <= 20; c++) begin
            tick();
            xif.req_valid = 1'b0;
            tests++; if (xif.rsp_valid !== (c == 19)) begin fails++; $display("FAIL rstm_rd_rsp_valid c%0d: got %b exp %b", c, xif.rsp_valid, c == 19); end
            if (c == 19) begin
                tests++; if (xif.rsp_err !== 1'b0) begin fails++; $display("FAIL rstm_rd_rsp_err: got %b exp 0", xif.rsp_err); end
            end
            xif.rd_valid = (c >= 3 && c <= 18);
            xif.common_data_bus_read_in = 32'h4444_0000 + 32'(c - 3);
            xif.tx_done = (c == 18);
        end
        for (int i = 0; i < 16; i++) expLine[i*32 +: 32] = 32'h4444_0000 + 32'(i);
        tests++; if (xif.rsp_rdata !== expLine) begin fails++; $display("FAIL rstm_rd_line: got %h exp %h", xif.rsp_rdata, expLine); end
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] a3;
        logic [CL-1:0] w2;
        logic [CL-1:0] w3;
        logic [WS-1:0] eb;
        a3 = 64'h0000_00FE_0000_0F00;
        for (int i = 0; i < 16; i++) begin
            w2[i*32 +: 32] = 32'hEEEE_0000 + 32'(i);
            w3[i*32 +: 32] = 32'h7700_0000 + 32'(i);
        end
        xif.req_valid = 1'b1; xif.req_wr = 1'b0; xif.req_addr = 64'h300;
        xif.ready = 1'b1; xif.tx_done = 1'b0; xif.rd_valid = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (c <= 19) begin
                tests++; if (xif.req_ready !== 1'b0) begin fails++; $display("FAIL b2b_busy_ready c%0d: got %b exp 0", c, xif.req_ready); end
            end
            if (c == 19) begin
                tests++; if (xif.rsp_valid !== 1'b1) begin fails++; $display("FAIL b2b_rd_rsp: got %b exp 1", xif.rsp_valid); end
            end
            if (c == 20) begin
                tests++; if (xif.req_ready !== 1'b1) begin fails++; $display("FAIL b2b_accept_ready: got %b exp 1", xif.req_ready); end
            end
            if (c >= 21 && c <= 38) begin
                if (c == 21)      eb = a3[31:0];
                else if (c == 22) eb = a3[63:32];
                else              eb = w3[(c-23)*32 +: 32];
                tests++; if (xif.common_data_bus_write_out !== eb) begin fails++; $display("FAIL b2b_wr_bus c%0d: got %h exp %h", c, xif.common_data_bus_write_out, eb); end
                tests++; if (xif.op !== 2'b11) begin fails++; $display("FAIL b2b_wr_op c%0d: got %b exp 11", c, xif.op); end
            end
            if (c == 39) begin
                tests++; if (xif.rsp_valid !== 1'b1) begin fails++; $display("FAIL b2b_wr_rsp: got %b exp 1", xif.rsp_valid); end
            end
            // queued write request: provisional values while busy, final ones at the accept cycle
            if (c == 1) begin
                xif.req_wr = 1'b1; xif.req_addr = 64'hAAAA_AAAA_5555_5555; xif.req_wdata = w2;
            end
            if (c == 20) begin
                xif.req_addr = a3; xif.req_wdata = w3;
            end
            if (c == 21) begin
                xif.req_valid = 1'b0; xif.req_addr = 64'hFFFF_FFFF_FFFF_FFFF; xif.req_wdata = w2;
            end
            xif.rd_valid = (c >= 3 && c <= 18);
            xif.common_data_bus_read_in = 32'h3333_0000 + 32'(c - 3);
            xif.tx_done = (c == 18) || (c == 38);
        end
        for (int i = 0; i < 16; i++) expLine[i*32 +: 32] = 32'h3333_0000 + 32'(i);
        tests++; if (xif.rsp_rdata !== expLine) begin fails++; $display("FAIL b2b_rd_line: got %h exp %h", xif.rsp_rdata, expLine); end
    endtask

    initial begin
        test_reset();
        test_write_nostall();
        idle_inputs();
        tick();
        test_read_stall();
        idle_inputs();
        tick();
        test_write_stall();
        idle_inputs();
        tick();
        test_early_done();
        idle_inputs();
        tick();
        test_reset_mid();
        idle_inputs();
        tick();
        test_back_to_back();
        idle_inputs();
        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_blk_xfer_ctrl.md
# mem_blk_xfer_ctrl

Sequences a single 512-bit cache-line transfer over the 32-bit memory-controller interface. The block sits between the memory request arbiter (which picks the winning instruction-cache, data-cache or accelerator request) and the memory controller. It serializes the address and the 16 data beats, deserializes read data, and returns one completion per request. Only one transfer is outstanding at a time.

## Interface
Parameters:
- WORD_SIZE, 32, memory-controller bus width
- CL_SIZE_WIDTH, 512, cache-line width; beats = CL_SIZE_WIDTH/WORD_SIZE = 16
- ADDR_BITCOUNT, 64, request address width

Ports:
- clk  in  1  single clock; all state changes on posedge
- rst  in  1  asynchronous, active-low reset
- req_valid  in  1  arbiter has a granted request
- req_wr  in  1  1 = write line to memory, 0 = read line
- req_addr  in  ADDR_BITCOUNT  line address
- req_wdata  in  CL_SIZE_WIDTH  line to write; word 0 = bits [31:0]
- req_ready  out  1  block idle; request accepted when req_valid & req_ready
- rsp_valid  out  1  one-cycle completion pulse
- rsp_err  out  1  valid with rsp_valid; protocol error (early tx_done)
- rsp_rdata  out  CL_SIZE_WIDTH  assembled read line
- op  out  2  00 none, 01 read, 11 write (10 reserved, never driven)
- common_data_bus_write_out  out  WORD_SIZE  address/write-data beat
- common_data_bus_read_in  in  WORD_SIZE  read-data beat
- ready  in  1  controller accepts the current address/write beat
- tx_done  in  1  controller finished the transaction
- rd_valid  in  1  common_data_bus_read_in holds a valid read beat

## Operation
- States: IDLE, ADDR_LO, ADDR_HI, WR_DATA, RD_DATA, WAIT_DONE, RESP.
- IDLE: req_ready=1, op=00, bus=0. On accept, latch req_wr, req_addr and req_wdata, clear beat counter (4 bits), clear the error flag, and go to ADDR_LO.
- ADDR_LO: op=01/11, bus=addr[31:0]. Advance to ADDR_HI on ready.
- ADDR_HI: bus=addr[63:32]. On ready, go to WR_DATA if write, else RD_DATA.
- WR_DATA: bus=wdata word[beat]. Each ready increments beat. Ready on beat 15 goes to WAIT_DONE, or straight to RESP if tx_done is high in the same cycle.
- RD_DATA: bus=0. Each rd_valid writes read_in into rdata word[beat] and increments beat. rd_valid on beat 15 goes to WAIT_DONE, or straight to RESP if tx_done is high in the same cycle. ready is ignored.
- WAIT_DONE: op held. On tx_done, go to RESP.
- RESP: rsp_valid=1 for exactly one cycle, op=00, then IDLE.
- op stays constant and nonzero from ADDR_LO through WAIT_DONE.
- Early tx_done (in ADDR_LO, ADDR_HI, or WR/RD_DATA before the final beat): go directly to RESP with rsp_err=1. Partially written rdata words are kept.
- rsp_rdata holds its value until the next read overwrites words. Write requests never modify it.
- rd_valid outside RD_DATA and ready outside the address/write phases are ignored.
- req_valid while busy: ignored; the arbiter must hold the request until req_ready.
- Beat counter wraps 15→0 only on state exit; it is never used past 15.

## Timing
- Reset (async, rst=0): state=IDLE and counter=0, applied immediately. Outputs: req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0, op=00, bus=0.
- Reset mid-transfer aborts it with no rsp_valid; op drops to 00 without waiting for a clock.
- All outputs are decoded from registered state, counter and latched request. There is no combinational path from any input to any output.
- Minimum latency (ready/rd_valid always high, tx_done on final beat), taking the accept cycle as cycle 0:
  - ADDR_LO at cycle 1, ADDR_HI at cycle 2
  - data beats at cycles 3–18
  - rsp_valid at cycle 19
  - req_ready high again at cycle 20
- Each cycle ready (write) or rd_valid (read) is low stalls the current beat by one cycle. The bus value holds during a stall.
- Back-to-back requests: the earliest next accept is the IDLE cycle after RESP, so the request-to-request period is ≥ 20 cycles.

## Test plan
- Write, zero stalls: addr=0x0000_0001_0000_0040, wdata word i = 0xA000_0000+i. Required bus sequence: 0x0000_0040, 0x0000_0001, then 0xA000_0000..0xA000_000F. op=11 for cycles 1–18; rsp_valid at cycle 19 with rsp_err=0.
- Read with stalls: addr=0x80, rd_valid pattern 1,0,0,1,…, beats 0x1111_0000+i. Required: rsp_rdata word i = 0x1111_0000+i, op=01 throughout, one rsp_valid, rsp_err=0.
- ready low 3 cycles during ADDR_HI and low 2 cycles at write beat 7. Required: bus holds addr[63:32] and word 7 during the stalls, no beat skipped or duplicated, rsp_valid 5 cycles later than the zero-stall case.
- tx_done asserted at read beat 5. Required: RESP next cycle with rsp_err=1, words 0–4 updated, words 5–15 unchanged; the next request completes with rsp_err=0.
- rst driven low at write beat 9. Required: op=00, req_ready=1 and rsp_valid=0 asynchronously. After release, a new read completes normally.
- req_valid held through a busy read with a second write request queued. Required: the second request is accepted exactly at the IDLE cycle after RESP, and its latched address and data are the values present at that accept, not at first assertion.
